// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with write bypass and busy scoreboard
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] release_vec;

    // A write to any port frees its destination; register 0 is never tracked.
    always_comb begin
        release_vec = '0;
        for (int i = 1; i < NREGS; i++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(i))
                    release_vec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy <= '0;
        end else begin
            // Ascending port order lets the higher-numbered port win a collision.
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
            // Reserve has priority over release so a reissued destination stays busy.
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_en && rsv_addr == AW'(i))
                    busy[i] <= 1'b1;
                else if (release_vec[i])
                    busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            d = (a == '0) ? '0 : regs[a];
            // Forwarding is suppressed while reset is held so every read sees zero.
            if (BYPASS != 0 && !reset && a != '0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == a)
                        d = wr_data[j*XLEN +: XLEN];
                end
            end
            rd_data[k*XLEN +: XLEN] = d;
            rd_busy[k]              = busy[a];
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp (bypass, no-bypass and wide variants)
module tb_regfile_mp;

    localparam int K_RD   = 0;
    localparam int K_BUSY = 1;
    localparam int K_VEC  = 2;
    localparam int K_NB   = 3;
    localparam int K_W    = 4;

    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared stimulus for the bypass and no-bypass instances
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] busy_vec, nb_busy_vec;

    logic [15:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic [0:0]   w_wr_en;
    logic [3:0]   w_wr_addr;
    logic [63:0]  w_wr_data;
    logic         w_rsv_en;
    logic [3:0]   w_rsv_addr;
    logic [15:0]  w_busy_vec;

    regfile_mp u_dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_vec(busy_vec)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .busy_vec(nb_busy_vec)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .NWR(1), .BYPASS(1)) u_wide (
        .clk(clk), .reset(reset), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data), .rsv_en(w_rsv_en),
        .rsv_addr(w_rsv_addr), .busy_vec(w_busy_vec)
    );

    // monitor: outputs are combinational, so every queued expectation is due at this negedge
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [63:0] act;
            e = q.pop_front();
            case (e.kind)
                K_RD:    act = {32'h0, rd_data[e.port*32 +: 32]};
                K_BUSY:  act = {63'h0, rd_busy[e.port]};
                K_VEC:   act = {32'h0, busy_vec};
                K_NB:    act = {32'h0, nb_rd_data[e.port*32 +: 32]};
                default: act = w_rd_data[e.port*64 +: 64];
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s port%0d: got %h expected %h", e.name, e.port, act, e.exp);
            end
        end
    end

    task automatic push(input string name, input int kind, input int port, input logic [63:0] exp);
        exp_t e;
        e.name = name; e.kind = kind; e.port = port; e.exp = exp;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
        w_wr_en = '0; w_wr_addr = '0; w_wr_data = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    logic [63:0] ref_w [16];
    logic [3:0]  wa_tab [6] = '{4'd1, 4'd15, 4'd0, 4'd8, 4'd1, 4'd15};
    logic [63:0] wd_tab [6] = '{64'hFFFF_FFFF_0000_0001, 64'h0123_4567_89AB_CDEF,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
                                64'h0000_0000_0000_0002, 64'h8000_0000_0000_0000};

    initial begin
        reset = 1'b1;
        idle();
        rd(5'd0, 5'd0);
        w_rsv_en = 1'b0; w_rsv_addr = '0; w_rd_addr = '0;
        for (int i = 0; i < 16; i++) ref_w[i] = '0;

        // writes presented during reset are discarded and not forwarded
        cyc();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF};
        rsv_en = 1'b1; rsv_addr = 5'd5;
        rd(5'd5, 5'd5);
        push("reset_rd_bypass", K_RD, 0, 64'h0);
        push("reset_vec", K_VEC, 0, 64'h0);
        cyc();
        reset = 1'b0;
        idle();

        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            push("reset_rd", K_RD, 0, 64'h0);
            push("reset_rd", K_RD, 1, 64'h0);
            push("reset_busy", K_BUSY, 0, 64'h0);
            push("reset_busy", K_BUSY, 1, 64'h0);
            if (i == 0) push("reset_vec", K_VEC, 0, 64'h0);
            cyc();
        end

        // reset asserted mid-write to x5
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF};
        #2 reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        rd(5'd5, 5'd5);
        push("midwrite_x5", K_RD, 0, 64'h0);
        push("midwrite_x5_nb", K_NB, 0, 64'h0);
        cyc();

        // bypass vs stored value on x3
        wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hA5A5_0001};
        rd(5'd3, 5'd3);
        push("x3_bypass", K_RD, 0, 64'hA5A5_0001);
        push("x3_nobypass_old", K_NB, 0, 64'h0);
        cyc();
        idle();
        push("x3_stored", K_RD, 1, 64'hA5A5_0001);
        push("x3_nobypass_new", K_NB, 0, 64'hA5A5_0001);
        cyc();

        // x0 write and reservation are ignored
        wr_en = 2'b10; wr_addr = {5'd0, 5'd0}; wr_data = {32'h1234, 32'h0};
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd(5'd0, 5'd0);
        push("x0_same", K_RD, 0, 64'h0);
        push("x0_same", K_RD, 1, 64'h0);
        cyc();
        idle();
        push("x0_next", K_RD, 0, 64'h0);
        push("x0_next", K_RD, 1, 64'h0);
        push("x0_next_nb", K_NB, 1, 64'h0);
        push("x0_busy_vec", K_VEC, 0, 64'h0);
        cyc();

        // collision on x7: port 1 wins
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h2222, 32'h1111};
        rd(5'd7, 5'd3);
        push("x7_collide_bypass", K_RD, 0, 64'h2222);
        push("x3_unaffected", K_RD, 1, 64'hA5A5_0001);
        cyc();
        idle();
        push("x7_collide_stored", K_RD, 0, 64'h2222);
        push("x7_collide_nb", K_NB, 0, 64'h2222);
        cyc();

        // scoreboard on x9
        rsv_en = 1'b1; rsv_addr = 5'd9;
        rd(5'd0, 5'd9);
        push("x9_rsv_same", K_BUSY, 1, 64'h0);
        cyc();
        idle();
        push("x9_rsv_next", K_BUSY, 1, 64'h1);
        push("x9_vec", K_VEC, 0, 64'h200);
        cyc();
        wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99};
        rsv_en = 1'b1; rsv_addr = 5'd9;
        push("x9_wr_rsv_same", K_BUSY, 1, 64'h1);
        cyc();
        idle();
        wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h9A, 32'h0};
        push("x9_reissue_busy", K_BUSY, 1, 64'h1);
        push("x9_reissue_vec", K_VEC, 0, 64'h200);
        cyc();
        idle();
        push("x9_released", K_BUSY, 1, 64'h0);
        push("x9_released_vec", K_VEC, 0, 64'h0);
        push("x9_data", K_RD, 1, 64'h9A);
        cyc();

        // wide variant against a small reference array
        for (int t = 0; t < 6; t++) begin
            logic [3:0] ra [4];
            w_wr_en = 1'b1; w_wr_addr = wa_tab[t]; w_wr_data = wd_tab[t];
            ra[0] = wa_tab[t]; ra[1] = 4'd0; ra[2] = 4'd15; ra[3] = 4'd1;
            w_rd_addr = {ra[3], ra[2], ra[1], ra[0]};
            for (int k = 0; k < 4; k++) begin
                logic [63:0] ex;
                ex = (ra[k] != 0 && ra[k] == wa_tab[t]) ? wd_tab[t] : ref_w[ra[k]];
                push("wide_rd", K_W, k, ex);
            end
            if (wa_tab[t] != 0) ref_w[wa_tab[t]] = wd_tab[t];
            cyc();
        end
        idle();
        w_rd_addr = {4'd8, 4'd15, 4'd0, 4'd1};
        push("wide_final", K_W, 0, ref_w[1]);
        push("wide_final", K_W, 1, 64'h0);
        push("wide_final", K_W, 2, ref_w[15]);
        push("wide_final", K_W, 3, ref_w[8]);
        cyc();

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
